// File: rtl/sample_write_packer_pkg.sv
// Shared types and constants for the sample write packer: line geometry, flush FSM states,
// the FIFO line entry and small mask/address helpers.
package sample_write_packer_pkg;

    localparam int unsigned PACKET_WIDTH     = 32;
    localparam int unsigned LINE_WIDTH       = 128;
    localparam int unsigned LANES            = LINE_WIDTH / PACKET_WIDTH;
    localparam int unsigned LANE_BITS        = $clog2(LANES);
    localparam int unsigned BYTES_PER_PACKET = PACKET_WIDTH / 8;
    localparam int unsigned MASK_WIDTH       = LINE_WIDTH / 8;
    localparam int unsigned ADX_WIDTH        = 27;
    localparam int unsigned BASE_WIDTH       = 32 - LANE_BITS;
    localparam int unsigned LINE_OFFSET_BITS = $clog2(MASK_WIDTH);

    typedef enum logic [1:0] {
        FlushIdle,
        FlushPush,
        FlushDrain,
        FlushDone
    } flushState_t;

    typedef struct packed {
        logic [LINE_WIDTH-1:0] data;
        logic [MASK_WIDTH-1:0] mask;
        logic [ADX_WIDTH-1:0]  adx;
    } lineEntry_t;

    function automatic logic [MASK_WIDTH-1:0] expandMask(input logic [LANES-1:0] laneValid);
        logic [MASK_WIDTH-1:0] result;
        result = '0;
        for (int k = 0; k < LANES; k++) begin
            result[k*BYTES_PER_PACKET +: BYTES_PER_PACKET] = {BYTES_PER_PACKET{laneValid[k]}};
        end
        return result;
    endfunction

    // Byte address of a line: the sample index base scaled to bytes, wrapped by truncation.
    function automatic logic [ADX_WIDTH-1:0] lineAdx(input logic [BASE_WIDTH-1:0] base);
        return ADX_WIDTH'({base, {LINE_OFFSET_BITS{1'b0}}});
    endfunction

endpackage

// File: rtl/packer_line_fifo.sv
// Synchronous FIFO of packed line entries; supports push and pop in the same cycle,
// including when full.
module packer_line_fifo
    import sample_write_packer_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  lineEntry_t               pushEntry,
    input  logic                     pop,
    output lineEntry_t               head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int unsigned PtrWidth = $clog2(DEPTH);

    lineEntry_t          mem [DEPTH];
    logic [PtrWidth-1:0] wrPtrQ, rdPtrQ;
    logic [PtrWidth:0]   countQ;
    logic                doPush, doPop;

    assign full      = (countQ == (PtrWidth + 1)'(DEPTH));
    assign empty     = (countQ == '0);
    assign occupancy = countQ;
    assign head      = mem[rdPtrQ];
    assign doPop     = pop && !empty;
    assign doPush    = push && (!full || doPop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtrQ <= '0;
            rdPtrQ <= '0;
            countQ <= '0;
        end else begin
            if (doPush) wrPtrQ <= wrPtrQ + 1'b1;
            if (doPop)  rdPtrQ <= rdPtrQ + 1'b1;
            countQ <= countQ + (PtrWidth + 1)'(doPush) - (PtrWidth + 1)'(doPop);
        end
    end

    // Storage needs no reset; the top gates outputs while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtrQ] <= pushEntry;
    end

endmodule

// File: rtl/sample_write_packer.sv
// Packs 32-bit sample packets into 128-bit masked memory lines and queues them for the memory
// write port. Define SAMPLE_WRITE_PACKER_STATS_EN to enable the transfer/drop counters.
module sample_write_packer #(
    parameter int unsigned SAMPLE_PACKET_WIDTH = 32,
    parameter int unsigned LINE_WIDTH          = 128,
    parameter int unsigned FIFO_DEPTH          = 4,
    parameter int unsigned ADX_WIDTH           = 27
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [SAMPLE_PACKET_WIDTH-1:0] samplePacket,
    input  logic                           write_enable,
    input  logic [31:0]                    sample_number,
    input  logic                           flush,
    output logic                           pageFull,
    output logic                           wr_req,
    input  logic                           wr_allowed,
    output logic [LINE_WIDTH-1:0]          wr_data,
    output logic [LINE_WIDTH/8-1:0]        wr_mask,
    output logic [ADX_WIDTH-1:0]           wr_adx,
    output logic                           flush_done,
    output logic                           overflow,
    output logic [31:0]                    lines_written,
    output logic [31:0]                    dropped_packets
);
    import sample_write_packer_pkg::*;

    localparam int unsigned OccWidth = $clog2(FIFO_DEPTH) + 1;
    localparam logic [OccWidth-1:0] PageFullLevel = OccWidth'(FIFO_DEPTH - 1);

    logic [LINE_WIDTH-1:0] asmDataQ, asmDataD;
    logic [LANES-1:0]      laneValidQ, laneValidD;
    logic [BASE_WIDTH-1:0] curBaseQ, curBaseD;
    logic                  asmOpenQ, asmOpenD;
    flushState_t           stateQ, stateD;
    logic                  pageFullQ, overflowQ;

    logic [LANE_BITS-1:0]  laneSel;
    logic [BASE_WIDTH-1:0] pktBase;
    logic [LINE_WIDTH-1:0] mergedData;
    logic [LANES-1:0]      mergedValid;
    logic                  pop, room, accept, drop, sameLine, push, flushPush;
    lineEntry_t            pushEntry, head;
    logic                  fifoFull, fifoEmpty;
    logic [OccWidth-1:0]   occupancy, occNext;

    assign laneSel = sample_number[LANE_BITS-1:0];
    assign pktBase = sample_number[31:LANE_BITS];

    always_comb begin
        pop         = !fifoEmpty && wr_allowed;
        room        = !fifoFull || pop;
        accept      = write_enable && room;
        drop        = write_enable && !room;
        sameLine    = asmOpenQ && (curBaseQ == pktBase);
        asmDataD    = asmDataQ;
        laneValidD  = laneValidQ;
        curBaseD    = curBaseQ;
        asmOpenD    = asmOpenQ;
        mergedData  = sameLine ? asmDataQ : '0;
        mergedValid = sameLine ? laneValidQ : '0;
        push        = 1'b0;
        flushPush   = 1'b0;
        pushEntry   = '{data: asmDataQ, mask: expandMask(laneValidQ), adx: lineAdx(curBaseQ)};

        mergedData[SAMPLE_PACKET_WIDTH*laneSel +: SAMPLE_PACKET_WIDTH] = samplePacket;
        mergedValid[laneSel] = 1'b1;

        if (accept) begin
            // A packet for a different line evicts the partial line through the push port.
            if (asmOpenQ && !sameLine) begin
                push = 1'b1;
            end
            if (&mergedValid) begin
                push       = 1'b1;
                pushEntry  = '{data: mergedData, mask: expandMask(mergedValid),
                               adx: lineAdx(pktBase)};
                asmOpenD   = 1'b0;
                laneValidD = '0;
            end else begin
                asmDataD   = mergedData;
                laneValidD = mergedValid;
                curBaseD   = pktBase;
                asmOpenD   = 1'b1;
            end
        end else if (stateQ == FlushPush && asmOpenQ && room) begin
            push       = 1'b1;
            flushPush  = 1'b1;
            asmOpenD   = 1'b0;
            laneValidD = '0;
        end
    end

    always_comb begin
        stateD     = stateQ;
        flush_done = 1'b0;
        unique case (stateQ)
            FlushIdle:  if (flush) stateD = FlushPush;
            FlushPush:  if (flushPush || (!asmOpenQ && !accept)) stateD = FlushDrain;
            FlushDrain: if (fifoEmpty) stateD = FlushDone;
            FlushDone: begin
                flush_done = 1'b1;
                stateD     = FlushIdle;
            end
            default:    stateD = FlushIdle;
        endcase
    end

    assign occNext = occupancy + OccWidth'(push) - OccWidth'(pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            asmDataQ   <= '0;
            laneValidQ <= '0;
            curBaseQ   <= '0;
            asmOpenQ   <= 1'b0;
            stateQ     <= FlushIdle;
            pageFullQ  <= 1'b0;
            overflowQ  <= 1'b0;
        end else begin
            asmDataQ   <= asmDataD;
            laneValidQ <= laneValidD;
            curBaseQ   <= curBaseD;
            asmOpenQ   <= asmOpenD;
            stateQ     <= stateD;
            pageFullQ  <= (occNext >= PageFullLevel);
            if (drop) overflowQ <= 1'b1;
        end
    end

    packer_line_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pushEntry(pushEntry),
        .pop      (pop),
        .head     (head),
        .full     (fifoFull),
        .empty    (fifoEmpty),
        .occupancy(occupancy)
    );

    assign pageFull = pageFullQ;
    assign overflow = overflowQ;
    assign wr_req   = !fifoEmpty;
    assign wr_data  = fifoEmpty ? '0 : head.data;
    assign wr_mask  = fifoEmpty ? '0 : head.mask;
    assign wr_adx   = fifoEmpty ? '0 : head.adx;

`ifdef SAMPLE_WRITE_PACKER_STATS_EN
    logic [31:0] linesWrittenQ, droppedQ;

    always_ff @(posedge clk) begin
        if (reset) begin
            linesWrittenQ <= '0;
            droppedQ      <= '0;
        end else begin
            if (pop && linesWrittenQ != '1) linesWrittenQ <= linesWrittenQ + 1'b1;
            if (drop && droppedQ != '1)     droppedQ <= droppedQ + 1'b1;
        end
    end

    assign lines_written   = linesWrittenQ;
    assign dropped_packets = droppedQ;
`else
    assign lines_written   = 32'd0;
    assign dropped_packets = 32'd0;
`endif

endmodule

// File: tb/tb_sample_write_packer.sv
// Bench for sample_write_packer: directed scenarios plus random traffic against a queue-based
// model of line assembly, the line FIFO and the flush sequence.
module tb_sample_write_packer;

    typedef struct packed {
        logic [127:0] data;
        logic [15:0]  mask;
        logic [26:0]  adx;
    } line_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  samplePacket;
    logic         write_enable;
    logic [31:0]  sample_number;
    logic         flush;
    logic         pageFull;
    logic         wr_req;
    logic         wr_allowed;
    logic [127:0] wr_data;
    logic [15:0]  wr_mask;
    logic [26:0]  wr_adx;
    logic         flush_done;
    logic         overflow;
    logic [31:0]  lines_written;
    logic [31:0]  dropped_packets;

    always #5 clk = ~clk;

    sample_write_packer dut (
        .clk            (clk),
        .reset          (reset),
        .samplePacket   (samplePacket),
        .write_enable   (write_enable),
        .sample_number  (sample_number),
        .flush          (flush),
        .pageFull       (pageFull),
        .wr_req         (wr_req),
        .wr_allowed     (wr_allowed),
        .wr_data        (wr_data),
        .wr_mask        (wr_mask),
        .wr_adx         (wr_adx),
        .flush_done     (flush_done),
        .overflow       (overflow),
        .lines_written  (lines_written),
        .dropped_packets(dropped_packets)
    );

    int unsigned tests = 0;
    int unsigned fails = 0;

    // Reference model: a queue of pending lines plus the line under assembly.
    line_t       q[$];
    line_t       dutLog[$];
    bit          mOpen;
    logic [29:0] mBase;
    logic [31:0] mLane[4];
    bit          mValid[4];
    int          mPhase;       // 0 idle, 1 push, 2 drain, 3 done
    bit          mOverflow;
    longint      mLines, mDropped;
    int          flushDoneSeen;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic line_t buildLine();
        line_t  l;
        longint lineBase;
        l = '0;
        for (int k = 0; k < 4; k++) begin
            if (mValid[k]) begin
                l.data[32*k +: 32] = mLane[k];
                l.mask[4*k +: 4]   = 4'hF;
            end
        end
        lineBase = longint'(mBase) * 4;
        l.adx    = 27'(lineBase * 4);
        return l;
    endfunction

    function automatic logic [127:0] bitMask(input logic [15:0] m);
        logic [127:0] r;
        for (int b = 0; b < 16; b++) r[8*b +: 8] = {8{m[b]}};
        return r;
    endfunction

    task automatic closeLine();
        mOpen = 0;
        for (int k = 0; k < 4; k++) mValid[k] = 0;
    endtask

    task automatic modelStep();
        int          pre, lane;
        bit          pop, room, acc;
        logic [29:0] base;
        if (reset) begin
            q.delete();
            closeLine();
            mPhase = 0; mOverflow = 0; mLines = 0; mDropped = 0;
            return;
        end
        pre  = q.size();
        pop  = (pre > 0) && wr_allowed;
        room = (pre < 4) || pop;
        acc  = 0;
        if (pop) begin
            void'(q.pop_front());
            if (mLines < 64'hFFFF_FFFF) mLines++;
        end
        if (write_enable) begin
            if (room) begin
                acc  = 1;
                base = sample_number[31:2];
                lane = int'(sample_number[1:0]);
                if (mOpen && mBase != base) begin
                    q.push_back(buildLine());
                    closeLine();
                end
                if (!mOpen) begin
                    mOpen = 1;
                    mBase = base;
                end
                mLane[lane]  = samplePacket;
                mValid[lane] = 1;
                if (mValid[0] && mValid[1] && mValid[2] && mValid[3]) begin
                    q.push_back(buildLine());
                    closeLine();
                end
            end else begin
                mOverflow = 1;
                if (mDropped < 64'hFFFF_FFFF) mDropped++;
            end
        end
        case (mPhase)
            0: if (flush) mPhase = 1;
            1: if (!acc) begin
                if (!mOpen) mPhase = 2;
                else if (room) begin
                    q.push_back(buildLine());
                    closeLine();
                    mPhase = 2;
                end
            end
            2: if (pre == 0) mPhase = 3;
            default: mPhase = 0;
        endcase
    endtask

    task automatic step();
        bit           hold, xfer;
        logic [127:0] hd;
        logic [26:0]  ha;
        line_t        cur;
        logic [31:0]  expLines, expDrop;
        hold = (wr_req === 1'b1) && (wr_allowed === 1'b0) && (reset === 1'b0);
        xfer = (wr_req === 1'b1) && (wr_allowed === 1'b1) && (reset === 1'b0);
        hd   = wr_data;
        ha   = wr_adx;
        cur  = '{data: wr_data, mask: wr_mask, adx: wr_adx};
        @(posedge clk);
        modelStep();
        #1;
        if (xfer) dutLog.push_back(cur);
        if (flush_done === 1'b1) flushDoneSeen++;
`ifdef SAMPLE_WRITE_PACKER_STATS_EN
        expLines = 32'(mLines);
        expDrop  = 32'(mDropped);
`else
        expLines = 32'd0;
        expDrop  = 32'd0;
`endif
        check("wr_req", wr_req, q.size() > 0);
        if (q.size() > 0) begin
            check("head_data", wr_data & bitMask(q[0].mask), q[0].data);
            check("head_mask", wr_mask, q[0].mask);
            check("head_adx", wr_adx, q[0].adx);
        end
        check("pageFull", pageFull, q.size() >= 3);
        check("overflow", overflow, mOverflow);
        check("flush_done", flush_done, mPhase == 3);
        check("lines_written", lines_written, expLines);
        check("dropped_packets", dropped_packets, expDrop);
        if (hold) begin
            check("hold_data", wr_data, hd);
            check("hold_adx", wr_adx, ha);
        end
    endtask

    task automatic send(input logic [31:0] sn, input logic [31:0] pkt);
        write_enable  = 1'b1;
        sample_number = sn;
        samplePacket  = pkt;
        step();
        write_enable  = 1'b0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        dutLog.delete();
    endtask

    task automatic waitLogs(input int n, input int budget);
        for (int i = 0; i < budget && dutLog.size() < n; i++) step();
        check("log_count", dutLog.size(), n);
    endtask

    initial begin
        logic [31:0] sn;
        reset = 1'b1; write_enable = 1'b0; flush = 1'b0; wr_allowed = 1'b0;
        samplePacket = '0; sample_number = '0;
        closeLine();

        // Reset values
        doReset();
        check("rst_data", wr_data, 128'd0);
        check("rst_mask", wr_mask, 16'd0);
        check("rst_adx", wr_adx, 27'd0);

        // Sequential fill
        wr_allowed = 1'b1;
        for (int i = 0; i < 4; i++) send(32'(i), 32'hA0 + 32'(i));
        waitLogs(1, 10);
        if (dutLog.size() >= 1) begin
            check("seq_data", dutLog[0].data, 128'h000000A3_000000A2_000000A1_000000A0);
            check("seq_mask", dutLog[0].mask, 16'hFFFF);
            check("seq_adx", dutLog[0].adx, 27'h0);
        end

        // Gap then flush
        doReset();
        wr_allowed = 1'b1;
        send(32'd4, 32'h1111_0004);
        send(32'd5, 32'h1111_0005);
        send(32'd12, 32'h1111_000C);
        step(); step(); step();
        check("gap_count", dutLog.size(), 1);
        if (dutLog.size() >= 1) begin
            check("gap_data", dutLog[0].data[63:0], 64'h1111_0005_1111_0004);
            check("gap_mask", dutLog[0].mask, 16'h00FF);
            check("gap_adx", dutLog[0].adx, 27'h10);
        end
        flushDoneSeen = 0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int i = 0; i < 20 && flushDoneSeen == 0; i++) step();
        step();
        check("flush_done_count", flushDoneSeen, 1);
        check("flush_lines", dutLog.size(), 2);
        if (dutLog.size() >= 2) begin
            check("flush_mask", dutLog[1].mask, 16'h000F);
            check("flush_adx", dutLog[1].adx, 27'h30);
            check("flush_data", dutLog[1].data[31:0], 32'h1111_000C);
        end

        // Back-pressure and drops
        doReset();
        wr_allowed = 1'b0;
        for (int i = 0; i < 20; i++) begin
            send(32'(i), 32'hB000 + 32'(i));
            if (i == 7)  check("bp_pagefull_2", pageFull, 1'b0);
            if (i == 11) check("bp_pagefull_3", pageFull, 1'b1);
        end
        check("bp_overflow", overflow, 1'b1);
`ifdef SAMPLE_WRITE_PACKER_STATS_EN
        check("bp_dropped", dropped_packets, 32'd4);
`else
        check("bp_dropped", dropped_packets, 32'd0);
`endif
        wr_allowed = 1'b1;
        waitLogs(4, 20);
        if (dutLog.size() >= 4) check("bp_last_adx", dutLog[3].adx, 27'h30);
        check("bp_overflow_sticky", overflow, 1'b1);

        // Hold while the memory stalls
        doReset();
        for (int c = 0; c < 200 && dutLog.size() < 3; c++) begin
            wr_allowed = ((c / 3) % 2) == 1;
            if (c < 12) begin
                write_enable  = 1'b1;
                sample_number = 32'd16 + 32'(c);
                samplePacket  = 32'hC000 + 32'(c);
            end else begin
                write_enable = 1'b0;
            end
            step();
        end
        write_enable = 1'b0;
        check("hold_count", dutLog.size(), 3);
        for (int i = 0; i < 3 && i < dutLog.size(); i++) begin
            check("hold_order", dutLog[i].adx, 27'h40 + 27'(16 * i));
        end

        // Reset mid-fill
        doReset();
        wr_allowed = 1'b1;
        send(32'd0, 32'hDEAD_0000);
        send(32'd1, 32'hDEAD_0001);
        doReset();
        for (int i = 0; i < 4; i++) send(32'd8 + 32'(i), 32'hE000 + 32'(i));
        waitLogs(1, 10);
        if (dutLog.size() >= 1) begin
            check("rst_mid_adx", dutLog[0].adx, 27'h20);
            check("rst_mid_mask", dutLog[0].mask, 16'hFFFF);
            check("rst_mid_data", dutLog[0].data, 128'h0000E003_0000E002_0000E001_0000E000);
        end

        // Address wrap
        doReset();
        for (int i = 0; i < 4; i++) send(32'h0FFF_FFFC + 32'(i), 32'hF0 + 32'(i));
        waitLogs(1, 10);
        if (dutLog.size() >= 1) check("wrap_adx", dutLog[0].adx, 27'h7FF_FFF0);

        // Random traffic
        doReset();
        sn = $urandom;
        for (int c = 0; c < 800; c++) begin
            int r;
            wr_allowed = $urandom_range(0, 9) < 6;
            flush      = (mPhase == 0) && ($urandom_range(0, 39) == 0);
            r = $urandom_range(0, 19);
            if (r == 0)      sn = $urandom;
            else if (r == 1) sn = sn - 32'($urandom_range(0, 3));
            else             sn = sn + 32'd1;
            write_enable  = (mPhase == 0) && ($urandom_range(0, 9) < 7);
            sample_number = sn;
            samplePacket  = $urandom;
            step();
        end
        write_enable = 1'b0;
        wr_allowed   = 1'b1;
        flush        = (mPhase == 0);
        step();
        flush = 1'b0;
        for (int i = 0; i < 50 && mPhase != 0; i++) step();
        check("final_idle", wr_req, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
